int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt source controller that drives the hardware-interrupt and inter-processor-interrupt status bits consumed by the CSR unit. It synchronises asynchronous external interrupt lines, applies per-line polarity, level/edge mode and enable masking, and latches edge events until software clears them. It presents pending bits that map directly onto ESTAT.IS[9:2] (hardware lines) and ESTAT.IS[12] (IPI). It sits between the SoC interrupt pins and the CSR block.

## Interface

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (1..8); unused IS bits read 0.
- SYNC_STAGES, 2, synchroniser depth per line (≥2).

Ports:
- clk  input  1  core clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- ext_int  input  NUM_IRQ  asynchronous external interrupt lines.
- ipi_set  input  1  single-cycle pulse that sets the IPI pending bit.
- ipi_clr  input  1  single-cycle pulse that clears the IPI pending bit.
- cfg_we  input  1  configuration register write strobe.
- cfg_addr  input  2  register select: 0 MODE, 1 POL, 2 ENABLE, 3 PENDING.
- cfg_wdata  input  32  write data; bits [NUM_IRQ-1:0] used.
- cfg_rdata  output  32  combinational read of the register at cfg_addr; upper bits 0.
- hw_is  output  8  registered pending-and-enabled lines, to ESTAT.IS[9:2].
- ipi_is  output  1  registered IPI pending, to ESTAT.IS[12].
- int_any  output  1  OR of hw_is and ipi_is.

## Operation

- Registers (per line i):
  - MODE[i]: 1 = edge, 0 = level. Reset 0.
  - POL[i]: 1 = active-high/rising, 0 = active-low/falling. Reset all-ones.
  - ENABLE[i]: reset 0.
  - PENDING[i]:
    - Edge lines: sticky latch.
    - Level lines: reads the current normalised synchronised level.
    - Reset 0.
- Synchronisation:
  - Each ext_int[i] passes through SYNC_STAGES flops giving s[i].
  - One further flop holds s_d[i].
  - Normalised level n[i] = s[i] XNOR POL[i]; n_d[i] = s_d[i] XNOR POL[i].
- Level mode: hw_is[i] next = ENABLE[i] & n[i]. Not sticky; deasserts when the source deasserts.
- Edge mode:
  - Event when ENABLE[i] & n[i] & ~n_d[i]; the event sets PENDING[i].
  - Writing 1 to PENDING[i] clears it; writing 0 has no effect.
  - hw_is[i] next = ENABLE[i] & PENDING[i].
- Edges occurring while ENABLE[i]=0 are discarded and are not latched.
- Clearing ENABLE[i] does not clear PENDING[i]. Re-enabling exposes a previously latched event.
- Writing MODE changes the mode of each line and clears PENDING[i] for every line whose MODE bit changes.
- Writing POL does not by itself create an event. n_d is recomputed with the new POL in the same cycle, so no spurious edge results.
- PENDING writes to level-mode bits are ignored.
- IPI behaviour:
  - ipi_set sets the bit; ipi_clr clears it.
  - Simultaneous ipi_set and ipi_clr: set wins.
  - ipi_is next = IPI pending.
- Simultaneous events:
  - Edge event and W1C on the same line in the same cycle: set wins; PENDING stays 1.
  - cfg write is applied in the same cycle as the datapath update.
- Reset:
  - All registers go to their reset values and all sync flops clear.
  - hw_is = 0, ipi_is = 0, int_any = 0.
  - Reset asserted mid-operation discards every pending event.

## Timing

- ext_int transition to s: SYNC_STAGES clock edges (sampling uncertainty ±1 cycle).
- s to hw_is: 1 cycle, for both level and edge mode.
- Total: ext_int stable before edge 0 ⇒ hw_is high after edge SYNC_STAGES+1 (3 with the default).
- ipi_set at edge k ⇒ pending at k ⇒ ipi_is at k+1.
- W1C written at edge k ⇒ PENDING cleared at k ⇒ hw_is low after k+1.
- int_any is combinational from the registered hw_is and ipi_is; it has no additional latency.
- cfg_rdata is combinational; it reflects register state before the current-cycle write.
- A level pulse shorter than one clk period may be missed. An edge pulse must be held for ≥2 cycles to guarantee detection.

## Test plan

- Reset, then ENABLE=0xFF with MODE=0 and POL=0xFF; drive ext_int[3]=1 → hw_is=0x08 by cycle 3. Drop ext_int[3] → hw_is=0x00 three cycles later.
- MODE[5]=1, ENABLE[5]=1; pulse ext_int[5] high for 2 cycles → hw_is[5]=1 and stays high. Write PENDING=0x20 → hw_is[5]=0 one cycle later.
- Edge line: W1C in the same cycle a new rising edge is detected → PENDING[5] remains 1 and hw_is[5] remains 1.
- ENABLE[2]=0, edge mode, pulse ext_int[2] → no latch. Set ENABLE[2]=1 → hw_is[2]=0.
- POL[1]=0, level mode, ext_int[1]=0 → hw_is[1]=1. Toggle POL while the line is static → no edge latched in edge mode.
- ipi_set and ipi_clr asserted together → ipi_is=1 and int_any=1. Then ipi_clr alone → ipi_is=0 next cycle. Assert reset with events pending → all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt source controller: synchronises external lines, applies polarity,
// level/edge mode and enable masking, and drives ESTAT.IS hardware/IPI bits.
module int_ctrl #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] ext_int,
  input  logic               ipi_set,
  input  logic               ipi_clr,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic [7:0]         hw_is,
  output logic               ipi_is,
  output logic               int_any
);

  typedef enum logic [1:0] {
    REG_MODE    = 2'd0,
    REG_POL     = 2'd1,
    REG_ENABLE  = 2'd2,
    REG_PENDING = 2'd3
  } reg_sel_e;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s_d_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] pol_q;
  logic [NUM_IRQ-1:0] en_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] hw_q;
  logic               ipi_pend_q;
  logic               ipi_q;

  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] n;
  logic [NUM_IRQ-1:0] n_d;
  logic [NUM_IRQ-1:0] edge_ev;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [NUM_IRQ-1:0] pend_next;
  logic [NUM_IRQ-1:0] pend_view;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:NUM_IRQ];

  always_comb begin
    wdata    = cfg_wdata[NUM_IRQ-1:0];
    s        = sync_q[SYNC_STAGES-1];
    // Both levels use the same POL register, so a POL write cannot fake an edge.
    n        = ~(s ^ pol_q);
    n_d      = ~(s_d_q ^ pol_q);
    edge_ev  = mode_q & en_q & n & ~n_d;
    w1c      = (cfg_we && (cfg_addr == REG_PENDING)) ? (wdata & mode_q) : '0;
    mode_chg = (cfg_we && (cfg_addr == REG_MODE)) ? (wdata ^ mode_q) : '0;
    // Event beats W1C; a mode change on the line beats both.
    pend_next = (edge_ev | (pend_q & ~w1c)) & mode_q & ~mode_chg;
    pend_view = (mode_q & pend_q) | (~mode_q & n);
  end

  always_comb begin
    cfg_rdata = '0;
    case (reg_sel_e'(cfg_addr))
      REG_MODE:    cfg_rdata[NUM_IRQ-1:0] = mode_q;
      REG_POL:     cfg_rdata[NUM_IRQ-1:0] = pol_q;
      REG_ENABLE:  cfg_rdata[NUM_IRQ-1:0] = en_q;
      REG_PENDING: cfg_rdata[NUM_IRQ-1:0] = pend_view;
      default:     cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      s_d_q      <= '0;
      mode_q     <= '0;
      pol_q      <= '1;
      en_q       <= '0;
      pend_q     <= '0;
      hw_q       <= '0;
      ipi_pend_q <= 1'b0;
      ipi_q      <= 1'b0;
    end else begin
      sync_q[0] <= ext_int;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_d_q  <= s;
      pend_q <= pend_next;
      // Edge lines expose a new event immediately; W1C lands one cycle later.
      hw_q   <= en_q & ((mode_q & (pend_q | edge_ev)) | (~mode_q & n));
      ipi_pend_q <= ipi_set | (ipi_pend_q & ~ipi_clr);
      ipi_q      <= ipi_pend_q;
      if (cfg_we) begin
        case (reg_sel_e'(cfg_addr))
          REG_MODE:   mode_q <= wdata;
          REG_POL:    pol_q  <= wdata;
          REG_ENABLE: en_q   <= wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    hw_is              = '0;
    hw_is[NUM_IRQ-1:0] = hw_q;
  end

  assign ipi_is  = ipi_q;
  assign int_any = (|hw_q) | ipi_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_int_ctrl;

  localparam int NI = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ext_int = '0;
  logic        ipi_set = 1'b0;
  logic        ipi_clr = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic [7:0]  hw_is;
  logic        ipi_is;
  logic        int_any;

  int checks = 0;
  int failures = 0;

  int_ctrl #(.NUM_IRQ(NI), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .ext_int(ext_int), .ipi_set(ipi_set),
    .ipi_clr(ipi_clr), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .hw_is(hw_is),
    .ipi_is(ipi_is), .int_any(int_any)
  );

  always #5 clk = ~clk;

  // Behavioural model: smp[k] is ext_int as sampled k+1 edges ago.
  logic [7:0] m_mode, m_pol, m_en, m_pend, m_hw;
  logic [7:0] smp [SS+1];
  logic       m_ipi, m_ipi_is;
  bit         m_valid = 0;
  logic [7:0] ms, msd, npend, nhw;
  bit         lvl, lvl_d, rise;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [7:0] v;
    case (a)
      2'd0: v = m_mode;
      2'd1: v = m_pol;
      2'd2: v = m_en;
      default:
        for (int i = 0; i < NI; i++)
          v[i] = m_mode[i] ? m_pend[i] : (smp[SS-1][i] == m_pol[i]);
    endcase
    return {24'h0, v};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = '0; m_pol = 8'hFF; m_en = '0; m_pend = '0; m_hw = '0;
      m_ipi = 0; m_ipi_is = 0;
      for (int k = 0; k <= SS; k++) smp[k] = '0;
      m_valid = 1;
    end else if (m_valid) begin
      ms  = smp[SS-1];
      msd = smp[SS];
      for (int i = 0; i < NI; i++) begin
        lvl   = (ms[i] == m_pol[i]);
        lvl_d = (msd[i] == m_pol[i]);
        if (m_mode[i]) begin
          rise = m_en[i] && lvl && !lvl_d;
          if (rise) npend[i] = 1'b1;
          else if (cfg_we && cfg_addr == 2'd3 && cfg_wdata[i]) npend[i] = 1'b0;
          else npend[i] = m_pend[i];
          nhw[i] = m_en[i] && (m_pend[i] || rise);
        end else begin
          npend[i] = 1'b0;
          nhw[i]   = m_en[i] && lvl;
        end
        if (cfg_we && cfg_addr == 2'd0 && cfg_wdata[i] != m_mode[i]) npend[i] = 1'b0;
      end
      m_pend = npend;
      m_hw   = nhw;
      if (cfg_we) begin
        if (cfg_addr == 2'd0) m_mode = cfg_wdata[7:0];
        if (cfg_addr == 2'd1) m_pol  = cfg_wdata[7:0];
        if (cfg_addr == 2'd2) m_en   = cfg_wdata[7:0];
      end
      m_ipi_is = m_ipi;
      if (ipi_set) m_ipi = 1;
      else if (ipi_clr) m_ipi = 0;
      for (int k = SS; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = ext_int;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_hw_is", {24'h0, hw_is}, {24'h0, m_hw});
      chk("cyc_ipi_is", {31'h0, ipi_is}, {31'h0, m_ipi_is});
      chk("cyc_int_any", {31'h0, int_any}, {31'h0, (|m_hw) | m_ipi_is});
      chk("cyc_rdata", cfg_rdata, m_read(cfg_addr));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
    chk({name, "_model"}, m_read(a), exp);
  endtask

  task automatic lit_hw(input string name, input logic [7:0] exp);
    chk(name, {24'h0, hw_is}, {24'h0, exp});
    chk({name, "_model"}, {24'h0, m_hw}, {24'h0, exp});
  endtask

  initial begin
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    lit_hw("rst_hw", 8'h00);
    chk("rst_ipi", {31'h0, ipi_is}, 32'h0);
    chk("rst_any", {31'h0, int_any}, 32'h0);
    rd("rst_pol", 2'd1, 32'hFF);
    rd("rst_en", 2'd2, 32'h0);
    rd("rst_mode", 2'd0, 32'h0);

    // Level line 3
    wr(2'd2, 32'hFF);
    ext_int = 8'h08;
    step(2); lit_hw("lvl_early", 8'h00);
    step(1); lit_hw("lvl_on", 8'h08);
    ext_int = 8'h00;
    step(2); lit_hw("lvl_hold", 8'h08);
    step(1); lit_hw("lvl_off", 8'h00);

    // Edge line 5, sticky, then W1C
    wr(2'd0, 32'h20);
    ext_int = 8'h20;
    step(2);
    ext_int = 8'h00;
    step(1); lit_hw("edge_set", 8'h20);
    step(4); lit_hw("edge_sticky", 8'h20);
    rd("edge_pend_rd", 2'd3, 32'h20);
    wr(2'd3, 32'h20); lit_hw("w1c_lag", 8'h20);
    step(1); lit_hw("w1c_clear", 8'h00);

    // W1C coinciding with a new edge event: set wins
    ext_int = 8'h20;
    step(2);
    wr(2'd3, 32'h20); lit_hw("setwins_a", 8'h20);
    step(1); lit_hw("setwins_b", 8'h20);
    rd("setwins_pend", 2'd3, 32'h20);
    ext_int = 8'h00;
    wr(2'd3, 32'h20);
    step(1); lit_hw("setwins_clr", 8'h00);

    // Disabled edge line 2 discards events
    wr(2'd0, 32'h24);
    wr(2'd2, 32'hFB);
    ext_int = 8'h04;
    step(2);
    ext_int = 8'h00;
    step(3); lit_hw("dis_none", 8'h00);
    rd("dis_pend", 2'd3, 32'h00);
    wr(2'd2, 32'hFF);
    step(1); lit_hw("dis_reen", 8'h00);

    // Active-low level line 1, then POL toggles on a static edge line
    wr(2'd1, 32'hFD);
    step(1); lit_hw("pol_low", 8'h02);
    wr(2'd0, 32'h26);
    wr(2'd1, 32'hFF);
    wr(2'd1, 32'hFD);
    step(3); lit_hw("pol_noedge", 8'h00);
    rd("pol_pend", 2'd3, 32'h00);

    // IPI
    ipi_set = 1; ipi_clr = 1;
    step(1);
    ipi_set = 0; ipi_clr = 0;
    chk("ipi_lat", {31'h0, ipi_is}, 32'h0);
    step(1);
    chk("ipi_on", {31'h0, ipi_is}, 32'h1);
    chk("ipi_any", {31'h0, int_any}, 32'h1);
    ipi_clr = 1;
    step(1);
    ipi_clr = 0;
    chk("ipi_clr_lag", {31'h0, ipi_is}, 32'h1);
    step(1);
    chk("ipi_off", {31'h0, ipi_is}, 32'h0);

    // Reset with events pending
    ext_int = 8'h20;
    step(4); lit_hw("pre_rst", 8'h20);
    ipi_set = 1; step(1); ipi_set = 0; step(1);
    chk("pre_rst_ipi", {31'h0, ipi_is}, 32'h1);
    reset = 1'b1;
    step(1);
    lit_hw("mid_rst_hw", 8'h00);
    chk("mid_rst_ipi", {31'h0, ipi_is}, 32'h0);
    chk("mid_rst_any", {31'h0, int_any}, 32'h0);
    rd("mid_rst_mode", 2'd0, 32'h0);
    rd("mid_rst_pol", 2'd1, 32'hFF);
    reset = 1'b0;
    ext_int = 8'h00;
    step(3); lit_hw("post_rst", 8'h00);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) ext_int = ext_int ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      ipi_set   = ($urandom_range(0, 7) == 0);
      ipi_clr   = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      step(1);
    end
    cfg_we = 0; ipi_set = 0; ipi_clr = 0; reset = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
